// File: rtl/reg_file32.sv
// -----------------------------------------------------------------------------
// reg_file32 -- 2**AW x WIDTH register file: one write port, two read ports.
//
// Register 0 is hardwired to zero: writes to it are discarded and it always
// reads 0. The other registers load D on a rising Clk edge when selected by
// the write decode. Reads are purely combinational, with no write-to-read
// bypass, so a read of the address being written returns the old contents
// until the capturing edge. A synchronous clear wipes every register and
// takes priority over a simultaneous write.
//
// Ports
//   Clk  in   1      clock, all state changes on the rising edge
//   Clr  in   1      synchronous active-high clear of every register
//   We   in   1      write enable
//   Wn   in   AW     write register number
//   D    in   WIDTH  write data
//   Rna  in   AW     read port A register number
//   Rnb  in   AW     read port B register number
//   Qa   out  WIDTH  read port A data (combinational)
//   Qb   out  WIDTH  read port B data (combinational)
// -----------------------------------------------------------------------------
module reg_file32 #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             We,
    input  logic [AW-1:0]    Wn,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    Rna,
    input  logic [AW-1:0]    Rnb,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb
);

    localparam int NREG = 2 ** AW;

    logic [NREG-1:0]  wen_s;
    logic [WIDTH-1:0] regs_r [NREG];

    // Write decode: one-hot register enable, none for register 0 or We low.
    always_comb begin
        wen_s = {NREG{1'b0}};
        if (We && (Wn != {AW{1'b0}})) begin
            wen_s[Wn] = 1'b1;
        end else begin
            wen_s = {NREG{1'b0}};
        end
    end

    // Register storage: clear has priority over any write in the same cycle.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int k = 0; k < NREG; k++) begin
                regs_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            // Register 0 is pinned to zero so it is defined even before any clear.
            regs_r[0] <= {WIDTH{1'b0}};
            for (int k = 1; k < NREG; k++) begin
                if (wen_s[k]) begin
                    regs_r[k] <= D;
                end else begin
                    regs_r[k] <= regs_r[k];
                end
            end
        end
    end

    // Read port A: combinational mux, address 0 forced to zero.
    always_comb begin
        Qa = {WIDTH{1'b0}};
        if (Rna == {AW{1'b0}}) begin
            Qa = {WIDTH{1'b0}};
        end else begin
            Qa = regs_r[Rna];
        end
    end

    // Read port B: combinational mux, address 0 forced to zero.
    always_comb begin
        Qb = {WIDTH{1'b0}};
        if (Rnb == {AW{1'b0}}) begin
            Qb = {WIDTH{1'b0}};
        end else begin
            Qb = regs_r[Rnb];
        end
    end

endmodule

// File: tb/tb_reg_file32.sv
// -----------------------------------------------------------------------------
// tb_reg_file32 -- self-checking bench for reg_file32.
// Directed scenarios followed by randomized traffic, all checked against a
// simple array model of the register file that the bench keeps itself.
// -----------------------------------------------------------------------------
module tb_reg_file32;

    logic        Clk;
    logic        Clr;
    logic        We;
    logic [4:0]  Wn;
    logic [31:0] D;
    logic [4:0]  Rna;
    logic [4:0]  Rnb;
    logic [31:0] Qa;
    logic [31:0] Qb;

    int chk_cnt;
    int pass_cnt;

    // Reference model: plain array, register 0 never written.
    logic [31:0] model [32];

    reg_file32 #(.WIDTH(32), .AW(5)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .We  (We),
        .Wn  (Wn),
        .D   (D),
        .Rna (Rna),
        .Rnb (Rnb),
        .Qa  (Qa),
        .Qb  (Qb)
    );

    // Free-running 10-unit clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        return model[a];
    endfunction

    // Model of one rising edge under the given controls.
    task automatic model_edge(input logic clr, input logic we, input logic [4:0] wn,
                              input logic [31:0] d);
        if (clr) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wn != 5'd0) begin
            model[wn] = d;
        end
    endtask

    // One clock cycle: drive at negedge, capture at posedge, then idle controls.
    task automatic cycle(input logic clr, input logic we, input logic [4:0] wn,
                         input logic [31:0] d);
        @(negedge Clk);
        Clr = clr; We = we; Wn = wn; D = d;
        @(posedge Clk);
        model_edge(clr, we, wn, d);
        #1;
        Clr = 1'b0; We = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [4:0] b);
        Rna = a; Rnb = b;
        #1;
        chk($sformatf("%s_qa[%0d]", tag, a), Qa, exp_rd(a));
        chk($sformatf("%s_qb[%0d]", tag, b), Qb, exp_rd(b));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_check(tag, 5'(i), 5'(31 - i));
        end
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        Clr = 1'b0; We = 1'b0; Wn = 5'd0; D = 32'h0; Rna = 5'd0; Rnb = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset, then every address reads zero on both ports.
        cycle(1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            Rna = 5'(i); Rnb = 5'(i);
            #1;
            chk($sformatf("rst_qa[%0d]", i), Qa, 32'h0);
            chk($sformatf("rst_qb[%0d]", i), Qb, 32'h0);
        end

        // r1..r31 = index; read pairs (i, 31-i).
        for (int i = 1; i < 32; i++) cycle(1'b0, 1'b1, 5'(i), 32'(i));
        for (int i = 0; i < 32; i++) begin
            Rna = 5'(i); Rnb = 5'(31 - i);
            #1;
            chk($sformatf("fill_qa[%0d]", i), Qa, 32'(i));
            chk($sformatf("fill_qb[%0d]", 31 - i), Qb, 32'(31 - i));
        end

        // Write to register 0 is discarded.
        cycle(1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
        Rna = 5'd0; Rnb = 5'd0;
        #1;
        chk("r0_write_qa", Qa, 32'h0);
        chk("r0_write_qb", Qb, 32'h0);

        // Read-during-write: old value before the edge, new value after.
        cycle(1'b0, 1'b1, 5'd5, 32'h11111111);
        Rna = 5'd5; Rnb = 5'd5;
        @(negedge Clk);
        We = 1'b1; Wn = 5'd5; D = 32'h22222222;
        #1;
        chk("rdw_before", Qa, 32'h11111111);
        @(posedge Clk);
        model_edge(1'b0, 1'b1, 5'd5, 32'h22222222);
        #1;
        We = 1'b0;
        chk("rdw_after_qa", Qa, 32'h22222222);
        chk("rdw_after_qb", Qb, 32'h22222222);

        // Back-to-back writes to the same register leave the last value.
        cycle(1'b0, 1'b1, 5'd12, 32'h0BADF00D);
        cycle(1'b0, 1'b1, 5'd12, 32'h600DCAFE);
        rd_check("b2b", 5'd12, 5'd12);
        chk("b2b_abs", Qa, 32'h600DCAFE);

        // Clear beats a simultaneous write.
        cycle(1'b0, 1'b1, 5'd7, 32'hCAFEF00D);
        rd_check("r7_pre", 5'd7, 5'd5);
        cycle(1'b1, 1'b1, 5'd7, 32'h12345678);
        rd_check("clr_prio", 5'd7, 5'd7);
        chk("clr_prio_abs", Qa, 32'h0);
        sweep("post_clr");

        // We=0 holds r9, then a real write lands.
        cycle(1'b0, 1'b0, 5'd9, 32'hA5A5A5A5);
        rd_check("we0", 5'd9, 5'd9);
        chk("we0_abs", Qa, 32'h0);
        cycle(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5);
        rd_check("we1", 5'd9, 5'd9);
        chk("we1_abs", Qa, 32'hA5A5A5A5);

        // Undefined data with We=0 disturbs nothing.
        cycle(1'b0, 1'b0, 5'd9, 32'hxxxxxxxx);
        rd_check("xd", 5'd9, 5'd0);

        // Clr raised mid-cycle acts only at the next edge.
        @(negedge Clk);
        Clr = 1'b1;
        Rna = 5'd9;
        #1;
        chk("clr_mid_hold", Qa, 32'hA5A5A5A5);
        @(posedge Clk);
        model_edge(1'b1, 1'b0, 5'd0, 32'h0);
        #1;
        Clr = 1'b0;
        chk("clr_mid_edge", Qa, 32'h0);

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)),
                  32'($urandom));
            rd_check("rnd", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        sweep("final");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file32.md
REG_FILE32 -- requirements
Module: reg_file32

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register in bits.
REQ-002 Parameter AW, default 5, register address width; register count is 2**AW (32).
REQ-003 Clk  input  1  clock; all state changes on rising edge.
REQ-004 Clr  input  1  reset, synchronous, active-high.
REQ-005 We  input  1  write enable for the single write port.
REQ-006 Wn  input  AW  write register number.
REQ-007 D  input  WIDTH  write data.
REQ-008 Rna  input  AW  read port A register number.
REQ-009 Rnb  input  AW  read port B register number.
REQ-010 Qa  output  WIDTH  read port A data.
REQ-011 Qb  output  WIDTH  read port B data.

Function
REQ-012 Storage SHALL be 2**AW registers of WIDTH bits; register 0 is read-only zero.
REQ-013 Each register SHALL be a clocked WIDTH-bit register with per-register enable and clear, one per address.
REQ-014 Write decode SHALL assert exactly one register enable when We=1 and Wn!=0; no enable when We=0 or Wn=0.
REQ-015 On a rising Clk edge with Clr=0, We=1, Wn=k (k!=0), register k SHALL load D; all other registers hold.
REQ-016 Writes to Wn=0 SHALL be discarded; register 0 SHALL always read as 0.
REQ-017 Qa SHALL equal register[Rna] combinationally (zero-cycle read latency, no clock involved); Qb likewise from Rnb.
REQ-018 Rna and Rnb SHALL be independent; Rna=Rnb SHALL yield Qa=Qb.
REQ-019 Read-during-write to the same address: before the edge, the read port SHALL return the old contents; after the edge, the new contents. There is no write-to-read bypass.
REQ-020 A written value SHALL be visible on Qa/Qb in the same cycle immediately after the capturing edge, once the read mux settles.
REQ-021 Back-to-back writes to the same register on consecutive edges SHALL leave the last written value.
REQ-022 X/undefined D with We=0 SHALL NOT disturb any register.

Reset
REQ-023 On a rising Clk edge with Clr=1, all registers SHALL be cleared to 0 regardless of We, Wn and D.
REQ-024 Clr=1 together with We=1 SHALL give clear priority; the write is lost.
REQ-025 Clr SHALL have no effect between edges; assertion mid-cycle takes effect at the next rising edge only.
REQ-026 After reset, Qa and Qb SHALL read 0 for every address until a register is written.
REQ-027 Before the first reset, register contents are undefined; the bench SHALL apply Clr for at least 1 cycle before checking.

Verification
REQ-028 Clr=1 for 1 cycle, then sweep Rna/Rnb over 0..31 -> Qa=Qb=0 at every address.
REQ-029 Write r1=0x00000001 through r31=0x0000001F, one per cycle, then read all pairs (Rna=i, Rnb=31-i) -> Qa=i, Qb=31-i, with r0 reading 0.
REQ-030 We=1, Wn=0, D=0xDEADBEEF, then Rna=0 -> Qa=0x00000000.
REQ-031 r5=0x11111111 held; set Rna=5, We=1, Wn=5, D=0x22222222 -> Qa=0x11111111 before the edge, 0x22222222 after it.
REQ-032 r7=0xCAFEF00D; one cycle with Clr=1, We=1, Wn=7, D=0x12345678 -> r7 reads 0 afterwards.
REQ-033 Write r9=0xA5A5A5A5 with We=0 -> r9 is unchanged; then with We=1 -> r9=0xA5A5A5A5, and a random sweep over all other registers shows no corruption.
